// File: rtl/ps2_kbd_fifo.sv
// ============================================================================
// Module   : ps2_kbd_fifo
// Purpose  : PS/2 set-2 prefix decoder (E0/F0) feeding an event FIFO.
//            Optional make-repeat filter: PS2_KBD_FIFO_TYPEMATIC_FILTER_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_kbd_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [7:0]               ps2_kbd_code_i,
  input  logic                     ps2_kbd_strobe_i,
  input  logic                     ps2_kbd_err_i,
  input  logic                     clr_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output logic [9:0]               event_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    CODE_E0    = 8'hE0;
  localparam logic [7:0]    CODE_F0    = 8'hF0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_E0   = 2'd1,
    GOT_F0   = 2'd2,
    GOT_E0F0 = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            ext;
  logic            rel;
  logic            dec_push;
  logic [9:0]      dec_event;
  logic            filt_drop;
  logic            push_req;
  logic            do_push;
  logic            pop;
  logic            full;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            overflow;
  logic [9:0]      mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    dec_push   = 1'b0;
    ext        = (state == GOT_E0) || (state == GOT_E0F0);
    rel        = (state == GOT_F0) || (state == GOT_E0F0);
    dec_event  = {ext, rel, ps2_kbd_code_i};
    // An error pulse aborts any prefix and swallows a coincident strobe.
    if (clr_i || ps2_kbd_err_i) begin
      state_next = IDLE;
    end else if (ps2_kbd_strobe_i) begin
      case (ps2_kbd_code_i)
        CODE_E0: state_next = GOT_E0;
        CODE_F0: state_next = ext ? GOT_E0F0 : GOT_F0;
        default: begin
          state_next = IDLE;
          dec_push   = 1'b1;
        end
      endcase
    end
  end

`ifdef PS2_KBD_FIFO_TYPEMATIC_FILTER_EN
  logic [8:0] held;
  logic       held_valid;

  assign filt_drop = dec_push && !dec_event[8] && held_valid &&
                     (held == {dec_event[9], dec_event[7:0]});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      held_valid <= 1'b0;
      held       <= '0;
    end else if (clr_i) begin
      held_valid <= 1'b0;
    end else if (do_push) begin
      if (dec_event[8]) begin
        held_valid <= 1'b0;
      end else begin
        held_valid <= 1'b1;
        held       <= {dec_event[9], dec_event[7:0]};
      end
    end
  end
`else
  assign filt_drop = 1'b0;
`endif

  assign push_req = dec_push && !filt_drop;
  assign full     = (count == FULL_COUNT);
  assign pop      = valid_o && ready_i && !clr_i;
  // When full, a simultaneous pop frees the head slot that the push overwrites.
  assign do_push  = push_req && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clr_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && !do_push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= dec_event;
  end

  assign valid_o    = (count != '0);
  assign event_o    = valid_o ? mem[rd_ptr] : 10'h000;
  assign count_o    = count;
  assign overflow_o = overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_kbd_fifo.sv
// ============================================================================
// Module   : tb_ps2_kbd_fifo
// Purpose  : Directed vector table plus multi-cycle sequences for ps2_kbd_fifo.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_kbd_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] code = 8'h00;
  logic       strobe = 1'b0;
  logic       err = 1'b0;
  logic       clr = 1'b0;
  logic       ready = 1'b0;
  logic       valid;
  logic [9:0] evt;
  logic [4:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  ps2_kbd_fifo #(.DEPTH(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ps2_kbd_code_i   (code),
    .ps2_kbd_strobe_i (strobe),
    .ps2_kbd_err_i    (err),
    .clr_i            (clr),
    .ready_i          (ready),
    .valid_o          (valid),
    .event_o          (evt),
    .count_o          (count),
    .overflow_o       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic [7:0] code;
    logic       err;
    logic       clr;
    logic       rdy;
    logic       v;
    logic [9:0] ev;
    logic [4:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic stb, input logic [7:0] c, input logic e, input logic cl,
                     input logic rdy, input logic v, input logic [9:0] ev,
                     input logic [4:0] cnt, input logic ovf);
    vec_t t;
    t.stb = stb; t.code = c; t.err = e; t.clr = cl; t.rdy = rdy;
    t.v = v; t.ev = ev; t.cnt = cnt; t.ovf = ovf;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [9:0] ev,
                            input logic [4:0] cnt, input logic ovf);
    chk({tag, ".valid"},    32'(valid),    32'(v));
    chk({tag, ".event"},    32'(evt),      32'(ev));
    chk({tag, ".count"},    32'(count),    32'(cnt));
    chk({tag, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask

  // One clock: inputs applied between edges, pulses removed right after the edge.
  task automatic drive(input logic stb, input logic [7:0] c, input logic e,
                       input logic cl, input logic rdy);
    strobe = stb; code = c; err = e; clr = cl; ready = rdy;
    @(posedge clk);
    #1;
    strobe = 1'b0; err = 1'b0; clr = 1'b0; ready = 1'b0; code = 8'h00;
  endtask

  initial begin
    logic [9:0] expq[$];

    //    stb code  err clr rdy | v  event   cnt ovf
    add(1, 8'h1C, 0, 0, 0,  1, 10'h01C, 1, 0);
    add(1, 8'hF0, 0, 0, 0,  1, 10'h01C, 1, 0);
    add(1, 8'h1C, 0, 0, 0,  1, 10'h01C, 2, 0);
    add(0, 8'h00, 0, 0, 1,  1, 10'h11C, 1, 0);
    add(0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);
    add(0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);
    add(1, 8'hE0, 0, 0, 0,  0, 10'h000, 0, 0);
    add(1, 8'h75, 0, 0, 0,  1, 10'h275, 1, 0);
    add(1, 8'hE0, 0, 0, 0,  1, 10'h275, 1, 0);
    add(1, 8'hF0, 0, 0, 0,  1, 10'h275, 1, 0);
    add(1, 8'h75, 0, 0, 1,  1, 10'h375, 1, 0);
    add(1, 8'hE0, 0, 0, 0,  1, 10'h375, 1, 0);
    add(0, 8'h00, 1, 0, 0,  1, 10'h375, 1, 0);
    add(1, 8'h1C, 0, 0, 0,  1, 10'h375, 2, 0);
    add(0, 8'h00, 0, 0, 1,  1, 10'h01C, 1, 0);
    add(0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);
    add(1, 8'h1C, 1, 0, 0,  0, 10'h000, 0, 0);
    add(1, 8'hF0, 0, 0, 0,  0, 10'h000, 0, 0);
    add(1, 8'hE0, 0, 0, 0,  0, 10'h000, 0, 0);
    add(1, 8'h6B, 0, 0, 0,  1, 10'h26B, 1, 0);
    add(1, 8'hE0, 0, 0, 0,  1, 10'h26B, 1, 0);
    add(1, 8'hF0, 0, 0, 0,  1, 10'h26B, 1, 0);
    add(1, 8'hE0, 0, 0, 0,  1, 10'h26B, 1, 0);
    add(1, 8'h74, 0, 0, 0,  1, 10'h26B, 2, 0);
    add(1, 8'hF0, 0, 0, 0,  1, 10'h26B, 2, 0);
    add(1, 8'hF0, 0, 0, 0,  1, 10'h26B, 2, 0);
    add(1, 8'h12, 0, 0, 0,  1, 10'h26B, 3, 0);
    add(1, 8'hE1, 0, 0, 0,  1, 10'h26B, 4, 0);
    add(1, 8'hE0, 0, 0, 1,  1, 10'h274, 3, 0);
    add(0, 8'h00, 0, 1, 0,  0, 10'h000, 0, 0);
    add(1, 8'h1C, 0, 0, 0,  1, 10'h01C, 1, 0);
    add(0, 8'h00, 0, 0, 1,  0, 10'h000, 0, 0);

    // Reset state
    #1;
    expect_out("reset_async", 0, 10'h000, 0, 0);
    @(posedge clk);
    #1;
    expect_out("reset", 0, 10'h000, 0, 0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stb, vecs[i].code, vecs[i].err, vecs[i].clr, vecs[i].rdy);
      expect_out($sformatf("vec%0d", i), vecs[i].v, vecs[i].ev, vecs[i].cnt, vecs[i].ovf);
    end

    // Fill to full, overflow on the 17th, then push+pop while full
    for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    expect_out("full16", 1, 10'h001, 16, 0);
    drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    expect_out("overflow", 1, 10'h001, 16, 1);
    drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
    expect_out("full_push_pop", 1, 10'h002, 16, 1);
    for (int k = 3; k <= 16; k++) begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      expect_out($sformatf("drain%0d", k), 1, 10'(k), 5'(18 - k), 1);
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_out("drain_last", 1, 10'h020, 1, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    expect_out("drain_empty", 0, 10'h000, 0, 1);

    // Clear with three queued, overflow sticky, and a coincident strobe
    drive(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h32, 1'b0, 1'b0, 1'b0);
    expect_out("pre_clr", 1, 10'h030, 3, 1);
    drive(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    expect_out("clr", 0, 10'h000, 0, 0);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_out("post_clr", 0, 10'h000, 0, 0);

    // Typematic repeat sequence
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
`ifdef PS2_KBD_FIFO_TYPEMATIC_FILTER_EN
    expq = '{10'h01C, 10'h11C, 10'h01C};
`else
    expq = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
    chk("typematic.count", 32'(count), 32'(expq.size()));
    foreach (expq[j]) begin
      chk($sformatf("typematic.ev%0d", j), 32'(evt), 32'(expq[j]));
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    end
    chk("typematic.empty", 32'(valid), 32'd0);

    // Reset in the middle of an E0 prefix
    drive(1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
    expect_out("pre_reset", 1, 10'h040, 1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    expect_out("mid_reset", 0, 10'h000, 0, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    expect_out("after_reset", 1, 10'h01C, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
